// File: rtl/div_unit.sv
// Sequential signed restoring divider for the DIV instruction: one quotient bit per
// clock, quotient to LO, remainder to HI, with a one-cycle done / divide-by-zero pulse.
module div_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             DivCtrl,
    output logic             DivDone,
    output logic             DivZero,
    output logic [WIDTH-1:0] DivCtrlHIOut,
    output logic [WIDTH-1:0] DivCtrlLOOut,
    output logic [CNT_W-1:0] counter
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t             state;
    logic [WIDTH-1:0]   dvd;        // dividend magnitude, refilled with quotient bits from the right
    logic [WIDTH-1:0]   dsr;        // divisor magnitude
    logic [WIDTH-1:0]   rem;
    logic               sign_q;
    logic               sign_r;
    logic               zero_flag;

    logic [WIDTH:0]     rem_shift;
    logic [WIDTH:0]     rem_diff;
    logic               q_bit;
    logic [WIDTH-1:0]   rem_next;
    logic [CNT_W-1:0]   cnt_inc;

    // Magnitude of a two's complement value; the most negative value maps to 2^(WIDTH-1).
    function automatic logic [WIDTH-1:0] abs_val(input logic signed [WIDTH-1:0] v);
        abs_val = v[WIDTH-1] ? WIDTH'(-v) : WIDTH'(v);
    endfunction

    function automatic logic [WIDTH-1:0] apply_sign(input logic [WIDTH-1:0] mag, input logic neg);
        apply_sign = neg ? WIDTH'(-mag) : mag;
    endfunction

    always_comb begin
        rem_shift = {rem, dvd[WIDTH-1]};
        rem_diff  = rem_shift - {1'b0, dsr};
        q_bit     = ~rem_diff[WIDTH];
        rem_next  = q_bit ? rem_diff[WIDTH-1:0] : rem_shift[WIDTH-1:0];
        cnt_inc   = counter + CNT_W'(1);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            dvd          <= '0;
            dsr          <= '0;
            rem          <= '0;
            sign_q       <= 1'b0;
            sign_r       <= 1'b0;
            zero_flag    <= 1'b0;
            counter      <= '0;
            DivDone      <= 1'b0;
            DivZero      <= 1'b0;
            DivCtrlHIOut <= '0;
            DivCtrlLOOut <= '0;
        end else begin
            DivDone <= 1'b0;
            DivZero <= 1'b0;
            case (state)
                IDLE: begin
                    if (DivCtrl) begin
                        if (B == '0) begin
                            zero_flag <= 1'b1;
                            state     <= DONE;
                        end else begin
                            dvd       <= abs_val(A);
                            dsr       <= abs_val(B);
                            sign_q    <= A[WIDTH-1] ^ B[WIDTH-1];
                            sign_r    <= A[WIDTH-1];
                            rem       <= '0;
                            counter   <= '0;
                            zero_flag <= 1'b0;
                            state     <= RUN;
                        end
                    end
                end
                RUN: begin
                    rem     <= rem_next;
                    dvd     <= {dvd[WIDTH-2:0], q_bit};
                    counter <= cnt_inc;
                    if (cnt_inc == CNT_W'(WIDTH)) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    DivCtrlLOOut <= apply_sign(dvd, sign_q);
                    DivCtrlHIOut <= apply_sign(rem, sign_r);
                    state        <= DONE;
                end
                DONE: begin
                    DivDone   <= 1'b1;
                    DivZero   <= zero_flag;
                    zero_flag <= 1'b0;
                    counter   <= '0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: table of signed divides plus hand-written sequences
// for start-ignored-while-busy and reset-in-flight.
module tb_div_unit;

    logic        clock;
    logic        reset;
    logic [31:0] A;
    logic [31:0] B;
    logic        DivCtrl;
    logic        DivDone;
    logic        DivZero;
    logic [31:0] DivCtrlHIOut;
    logic [31:0] DivCtrlLOOut;
    logic [5:0]  counter;

    int n_checks = 0;
    int n_fail   = 0;

    div_unit #(.WIDTH(32), .CNT_W(6)) dut (
        .clock        (clock),
        .reset        (reset),
        .A            (A),
        .B            (B),
        .DivCtrl      (DivCtrl),
        .DivDone      (DivDone),
        .DivZero      (DivZero),
        .DivCtrlHIOut (DivCtrlHIOut),
        .DivCtrlLOOut (DivCtrlLOOut),
        .counter      (counter)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] lo;
        logic [31:0] hi;
        logic        zero;
    } vec_t;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Issue one start pulse, wait (bounded) for DivDone and check results and timing.
    task automatic do_div(input string nm, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] elo, input logic [31:0] ehi, input logic ez);
        int k;
        int maxc;
        @(negedge clock);
        A = a; B = b; DivCtrl = 1'b1;
        @(posedge clock);
        @(negedge clock);
        DivCtrl = 1'b0;
        k = 0;
        maxc = 0;
        while (!DivDone && k < 60) begin
            if (int'(counter) > maxc) maxc = int'(counter);
            @(negedge clock);
            k++;
        end
        check({nm, "_latency"}, k, ez ? 1 : 34);
        check({nm, "_zero"}, {31'd0, DivZero}, {31'd0, ez});
        check({nm, "_lo"}, DivCtrlLOOut, elo);
        check({nm, "_hi"}, DivCtrlHIOut, ehi);
        check({nm, "_maxcnt"}, maxc, ez ? 0 : 32);
        @(negedge clock);
        check({nm, "_pulse_end"}, {31'd0, DivDone}, 32'd0);
        check({nm, "_cnt_idle"}, {26'd0, counter}, 32'd0);
    endtask

    task automatic wait_counter(input logic [5:0] target);
        int k;
        k = 0;
        while (counter != target && k < 60) begin
            @(negedge clock);
            k++;
        end
        check("wait_counter_timeout", {26'd0, counter}, {26'd0, target});
    endtask

    vec_t vecs[10];
    int pulses;

    initial begin
        vecs[0] = '{32'd100,       32'd7,          32'd14,         32'd2,          1'b0};
        vecs[1] = '{32'd5,         32'd0,          32'd14,         32'd2,          1'b1};
        vecs[2] = '{32'hFFFFFFF9,  32'd2,          32'hFFFFFFFD,   32'hFFFFFFFF,   1'b0};
        vecs[3] = '{32'd7,         32'hFFFFFFFE,   32'hFFFFFFFD,   32'd1,          1'b0};
        vecs[4] = '{32'h80000000,  32'hFFFFFFFF,   32'h80000000,   32'd0,          1'b0};
        vecs[5] = '{32'hFFFFFF9C,  32'hFFFFFFF9,   32'd14,         32'hFFFFFFFE,   1'b0};
        vecs[6] = '{32'd0,         32'd5,          32'd0,          32'd0,          1'b0};
        vecs[7] = '{32'h7FFFFFFF,  32'd1,          32'h7FFFFFFF,   32'd0,          1'b0};
        vecs[8] = '{32'h80000000,  32'h80000000,   32'd1,          32'd0,          1'b0};
        vecs[9] = '{32'hFFFFFFFF,  32'h80000000,   32'd0,          32'hFFFFFFFF,   1'b0};

        reset = 1'b1; A = '0; B = '0; DivCtrl = 1'b0;
        repeat (2) @(negedge clock);
        check("rst_done", {31'd0, DivDone}, 32'd0);
        check("rst_zero", {31'd0, DivZero}, 32'd0);
        check("rst_lo", DivCtrlLOOut, 32'd0);
        check("rst_hi", DivCtrlHIOut, 32'd0);
        check("rst_cnt", {26'd0, counter}, 32'd0);
        reset = 1'b0;

        for (int i = 0; i < 10; i++) begin
            do_div($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].lo, vecs[i].hi, vecs[i].zero);
        end

        // Start 100/7, then change operands and pulse DivCtrl mid-run: must be ignored.
        @(negedge clock);
        A = 32'd100; B = 32'd7; DivCtrl = 1'b1;
        @(negedge clock);
        DivCtrl = 1'b0;
        wait_counter(6'd10);
        A = 32'd9; B = 32'd3; DivCtrl = 1'b1;
        @(negedge clock);
        DivCtrl = 1'b0;
        pulses = 0;
        for (int k = 0; k < 45; k++) begin
            if (DivDone) pulses++;
            @(negedge clock);
        end
        check("busy_pulses", pulses, 1);
        check("busy_lo", DivCtrlLOOut, 32'd14);
        check("busy_hi", DivCtrlHIOut, 32'd2);

        // Start 100/7 and abort with reset at counter 15.
        do_div("pre_abort", 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0);
        @(negedge clock);
        A = 32'd100; B = 32'd7; DivCtrl = 1'b1;
        @(negedge clock);
        DivCtrl = 1'b0;
        wait_counter(6'd15);
        reset = 1'b1;
        #1;
        check("abort_lo", DivCtrlLOOut, 32'd0);
        check("abort_hi", DivCtrlHIOut, 32'd0);
        check("abort_cnt", {26'd0, counter}, 32'd0);
        check("abort_done", {31'd0, DivDone}, 32'd0);
        repeat (2) @(negedge clock);
        reset = 1'b0;
        pulses = 0;
        for (int k = 0; k < 40; k++) begin
            if (DivDone) pulses++;
            @(negedge clock);
        end
        check("abort_no_done", pulses, 0);
        do_div("post_abort", 32'd9, 32'd3, 32'd3, 32'd0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
Sequential signed 32-bit divider serving the DIV instruction, the counterpart of the existing Booth multiplier. It is started by the control FSM through DivCtrl and produces quotient and remainder for the HI/LO source muxes: DivCtrlLOOut feeds LO and DivCtrlHIOut feeds HI. It signals completion with a one-cycle done pulse and flags divide-by-zero so the control FSM can raise an exception.

Parameters:
WIDTH, 32, operand, quotient and remainder width.
CNT_W, 6, width of the iteration counter; must satisfy 2^CNT_W > WIDTH.

Ports:
clock  input  1  system clock; all state changes on the rising edge.
reset  input  1  asynchronous, active-high; clears all state.
A  input  WIDTH  dividend, two's complement (RegAOut).
B  input  WIDTH  divisor, two's complement (RegBOut).
DivCtrl  input  1  start request; sampled only in IDLE.
DivDone  output  1  one-cycle pulse: result valid on HI/LO, or divide-by-zero detected.
DivZero  output  1  one-cycle pulse, coincident with DivDone, when B == 0 at start.
DivCtrlHIOut  output  WIDTH  remainder (registered).
DivCtrlLOOut  output  WIDTH  quotient (registered).
counter  output  CNT_W  iterations completed in RUN; 0 otherwise.

Behaviour:
- Reset (asynchronous, any state):
  - State goes to IDLE.
  - DivDone, DivZero, counter, DivCtrlHIOut and DivCtrlLOOut all become 0.
  - Internal operand, sign and partial-remainder registers are cleared.
- IDLE state:
  - On a clock edge with DivCtrl=1, A and B are captured; later A/B changes have no effect.
  - If B == 0: go to DONE with zero flag set. DivCtrlHIOut and DivCtrlLOOut keep their previous values.
  - Otherwise: store |A|, |B|, sign_q = A[31]^B[31] and sign_r = A[31]; clear partial remainder and counter; go to RUN.
- RUN state, restoring division, one quotient bit per edge, MSB first:
  - rem' = {rem[WIDTH-2:0], dividend MSB}; dividend shifts left.
  - If rem' >= |B| (unsigned, WIDTH+1-bit compare): rem = rem' - |B| and quotient bit = 1. Else rem = rem' and quotient bit = 0.
  - counter increments by 1 each edge. After the WIDTH-th iteration (counter == WIDTH), go to FIX.
- FIX state, one edge:
  - DivCtrlLOOut = sign_q ? -q : q.
  - DivCtrlHIOut = sign_r ? -rem : rem.
  - Go to DONE. Quotient truncates toward zero; remainder takes the sign of the dividend (MIPS semantics).
- DONE state:
  - DivDone=1 for exactly one cycle. DivZero=1 in the same cycle if the zero flag is set.
  - Next edge returns to IDLE; counter returns to 0.
- Latency:
  - Start edge t0; RUN edges t1..t32; FIX edge t33.
  - DivDone is high during the cycle after t34 (registered in DONE). Outputs are already valid after t33.
  - Divide-by-zero: DivDone and DivZero high in the cycle after t1.
- Output holding: DivCtrlHIOut and DivCtrlLOOut hold their values until the next successful division completes or reset is asserted.
- Overflow case: A=0x80000000, B=0xFFFFFFFF gives quotient 0x80000000 and remainder 0. This wraps with no exception and no flag.
- DivCtrl asserted in RUN, FIX or DONE is ignored; there is no queuing. DivCtrl held high across DONE starts a new division on the first IDLE edge.
- Reset in the middle of RUN aborts the operation: no DivDone and all outputs 0.

Test Plan:
- A=100, B=7, pulse DivCtrl -> after 34 edges DivDone=1 for one cycle, LO=14, HI=2, DivZero=0; counter reached 32.
- A=-7 (0xFFFFFFF9), B=2 -> LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1). Then A=7, B=-2 -> LO=-3, HI=1.
- Load LO=14/HI=2 via a prior divide, then A=5, B=0 -> DivDone=1 and DivZero=1 in the cycle after the start edge; HI/LO still 2/14; counter stays 0.
- A=0x80000000, B=0xFFFFFFFF -> LO=0x80000000, HI=0, DivZero=0.
- Start 100/7, change A/B to 9/3 and pulse DivCtrl at counter=10 -> result still 14/2; a single DivDone pulse.
- Start 100/7, assert reset at counter=15 -> immediate LO=HI=0, counter=0, no DivDone. After release, A=9, B=3 -> LO=3, HI=0.
